// File: rtl/iter_muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master drives an op and flush; the slave answers with ready and a one-cycle result.
interface iter_muldiv_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 7
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        opcode_i;
  logic [TAG_W-1:0]  tag_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              valid_o;
  logic [TAG_W-1:0]  tag_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [5:0]        flags_o;

  modport master (
    output flush_i, valid_i, opcode_i, tag_i, data1_i, data2_i,
    input  ready_o, valid_o, tag_o, hi_o, lo_o, flags_o
  );

  modport slave (
    input  flush_i, valid_i, opcode_i, tag_i, data1_i, data2_i,
    output ready_o, valid_o, tag_o, hi_o, lo_o, flags_o
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// Iterative signed/unsigned multiply and divide retiring STEP bits per cycle.
// Works on operand magnitudes, applies sign correction as the result is registered.
module iter_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int STEP   = 1,
  parameter int TAG_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  iter_muldiv_unit_if.slave bus
);
  localparam int N     = DATA_W / STEP;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] opd_q, hi_q, lo_q;
  logic              is_div_q, neg_a_q, neg_b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] hi_res_q, lo_res_q;
  logic [TAG_W-1:0]  tag_res_q;
  logic [5:0]        flags_res_q;

  logic              accept, load_out, div_zero;
  logic              in_div, in_signed, in_neg_a, in_neg_b;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W:0]   step_t;
  logic [DATA_W-1:0] step_h, step_l;
  logic [2*DATA_W-1:0] prod_mag, prod_res;
  logic [DATA_W-1:0] quot_res, rem_res;

  assign in_div    = bus.opcode_i[1];
  assign in_signed = ~bus.opcode_i[0];
  assign in_neg_a  = in_signed & bus.data1_i[DATA_W-1];
  assign in_neg_b  = in_signed & bus.data2_i[DATA_W-1];
  assign mag1      = in_neg_a ? -bus.data1_i : bus.data1_i;
  assign mag2      = in_neg_b ? -bus.data2_i : bus.data2_i;
  assign div_zero  = in_div && (bus.data2_i == '0);

  // One iteration = STEP shift-add (multiply) or restoring-subtract (divide) steps.
  always_comb begin
    step_t = '0;
    step_h = hi_q;
    step_l = lo_q;
    for (int s = 0; s < STEP; s++) begin
      if (is_div_q) begin
        step_t = {step_h, step_l[DATA_W-1]};
        step_l = {step_l[DATA_W-2:0], 1'b0};
        if (step_t >= {1'b0, opd_q}) begin
          step_t    = step_t - {1'b0, opd_q};
          step_l[0] = 1'b1;
        end
        step_h = step_t[DATA_W-1:0];
      end else begin
        step_t = {1'b0, step_h} + (step_l[0] ? {1'b0, opd_q} : {(DATA_W+1){1'b0}});
        step_l = {step_t[0], step_l[DATA_W-1:1]};
        step_h = step_t[DATA_W:1];
      end
    end
  end

  assign prod_mag = {step_h, step_l};
  assign prod_res = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
  assign quot_res = (neg_a_q ^ neg_b_q) ? -step_l : step_l;
  assign rem_res  = neg_a_q ? -step_h : step_h;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign load_out    = (state_d == DONE) && (state_q != DONE);
  assign bus.ready_o = (state_q == IDLE) && !bus.flush_i;
  assign bus.valid_o = (state_q == DONE) && !bus.flush_i;
  assign bus.hi_o    = hi_res_q;
  assign bus.lo_o    = lo_res_q;
  assign bus.tag_o   = tag_res_q;
  assign bus.flags_o = flags_res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opd_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      is_div_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      tag_q       <= '0;
      hi_res_q    <= '0;
      lo_res_q    <= '0;
      tag_res_q   <= '0;
      flags_res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        opd_q    <= in_div ? mag2 : mag1;
        hi_q     <= '0;
        lo_q     <= in_div ? mag1 : mag2;
        is_div_q <= in_div;
        neg_a_q  <= in_neg_a;
        neg_b_q  <= in_neg_b;
        tag_q    <= bus.tag_i;
      end else if (state_q == CALC) begin
        hi_q <= step_h;
        lo_q <= step_l;
      end
      // DONE entry straight from IDLE only happens for divide by zero.
      if (load_out) begin
        if (state_q == IDLE) begin
          hi_res_q    <= bus.data1_i;
          lo_res_q    <= '1;
          tag_res_q   <= bus.tag_i;
          flags_res_q <= 6'b010110;
        end else begin
          hi_res_q    <= is_div_q ? rem_res  : prod_res[2*DATA_W-1:DATA_W];
          lo_res_q    <= is_div_q ? quot_res : prod_res[DATA_W-1:0];
          tag_res_q   <= tag_q;
          flags_res_q <= 6'b010100;
        end
      end
    end
  end
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed bench for iter_muldiv_unit (DATA_W=32, STEP=1) with hand-computed results.
// Covers latency, signed/unsigned math, divide by zero, flush, busy-ignore and reset abort.
module tb_iter_muldiv_unit;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   t_acc;
  int   seen;

  iter_muldiv_unit_if #(.DATA_W(32), .TAG_W(7)) bus ();

  iter_muldiv_unit #(.DATA_W(32), .STEP(1), .TAG_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] tag,
                       input logic [31:0] d1, input logic [31:0] d2);
    bus.valid_i  = 1'b1;
    bus.opcode_i = op;
    bus.tag_i    = tag;
    bus.data1_i  = d1;
    bus.data2_i  = d2;
    @(negedge clk);
    chk("ready_at_issue", {63'd0, bus.ready_o}, 64'd1);
    t_acc = cyc;
    next_cycle();
    bus.valid_i = 1'b0;
  endtask

  task automatic finish_op(input string nm, input int lat, input logic [6:0] tag,
                           input logic [31:0] hi, input logic [31:0] lo, input logic [5:0] flags);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(cyc - t_acc), 64'(lat));
    chk({nm, "_hi"}, {32'd0, bus.hi_o}, {32'd0, hi});
    chk({nm, "_lo"}, {32'd0, bus.lo_o}, {32'd0, lo});
    chk({nm, "_tag"}, {57'd0, bus.tag_o}, {57'd0, tag});
    chk({nm, "_flags"}, {58'd0, bus.flags_o}, {58'd0, flags});
    $display("op %s tag=%h hi=%h lo=%h flags=%h latency=%0d", nm, bus.tag_o, bus.hi_o,
             bus.lo_o, bus.flags_o, cyc - t_acc);
    next_cycle();
    @(negedge clk);
    chk({nm, "_pulse_end"}, {63'd0, bus.valid_o}, 64'd0);
    next_cycle();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.flush_i  = 1'b0;
    bus.valid_i  = 1'b0;
    bus.opcode_i = 2'b00;
    bus.tag_i    = '0;
    bus.data1_i  = '0;
    bus.data2_i  = '0;

    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    chk("rst_tag", {57'd0, bus.tag_o}, 64'd0);
    chk("rst_flags", {58'd0, bus.flags_o}, 64'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
    next_cycle();

    issue(OP_MULT, 7'h12, 32'hFFFFFFFD, 32'd5);
    finish_op("mult_m3x5", 33, 7'h12, 32'hFFFFFFFF, 32'hFFFFFFF1, 6'h14);

    issue(OP_MULTU, 7'h13, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("multu_max", 33, 7'h13, 32'hFFFFFFFE, 32'h00000001, 6'h14);

    issue(OP_MULT, 7'h14, 32'd7, 32'hFFFFFFFA);
    finish_op("mult_7xm6", 33, 7'h14, 32'hFFFFFFFF, 32'hFFFFFFD6, 6'h14);

    issue(OP_DIV, 7'h15, 32'hFFFFFFF9, 32'd2);
    finish_op("div_m7d2", 33, 7'h15, 32'hFFFFFFFF, 32'hFFFFFFFD, 6'h14);

    issue(OP_DIV, 7'h16, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_minneg", 33, 7'h16, 32'h00000000, 32'h80000000, 6'h14);

    issue(OP_DIVU, 7'h17, 32'd9, 32'd0);
    finish_op("divu_by0", 1, 7'h17, 32'd9, 32'hFFFFFFFF, 6'h16);

    // A second op presented while busy must be dropped.
    issue(OP_DIVU, 7'h40, 32'd100, 32'd7);
    bus.valid_i  = 1'b1;
    bus.opcode_i = OP_MULT;
    bus.tag_i    = 7'h41;
    bus.data1_i  = 32'h0000FFFF;
    bus.data2_i  = 32'h0000FFFF;
    @(negedge clk);
    chk("busy_ready", {63'd0, bus.ready_o}, 64'd0);
    next_cycle();
    bus.valid_i = 1'b0;
    finish_op("divu_100d7", 33, 7'h40, 32'd2, 32'd14, 6'h14);

    // Flush at T+10 of a MULT; a fresh op accepted at T+11 completes at T+44.
    issue(OP_MULT, 7'h21, 32'd7, 32'd9);
    repeat (9) next_cycle();
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("flush_valid", {63'd0, bus.valid_o}, 64'd0);
    next_cycle();
    bus.flush_i = 1'b0;
    issue(OP_MULTU, 7'h22, 32'd3, 32'd4);
    chk("flush_restart_at", 64'(t_acc), 64'(t_acc));
    @(negedge clk);
    chk("flush_hold_hi", {32'd0, bus.hi_o}, {32'd0, 32'd2});
    chk("flush_hold_lo", {32'd0, bus.lo_o}, {32'd0, 32'd14});
    chk("flush_hold_tag", {57'd0, bus.tag_o}, {57'd0, 7'h40});
    finish_op("multu_after_flush", 33, 7'h22, 32'd0, 32'd12, 6'h14);

    // Flush coinciding with DONE swallows the pulse.
    issue(OP_DIVU, 7'h30, 32'd5, 32'd0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", {63'd0, bus.valid_o}, 64'd0);
    next_cycle();
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_done_next_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("flush_done_ready", {63'd0, bus.ready_o}, 64'd1);
    next_cycle();

    // Reset at T+20 of a DIV aborts it and clears the result registers.
    issue(OP_DIV, 7'h50, 32'd1000, 32'd3);
    repeat (19) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("rstmid_hi", {32'd0, bus.hi_o}, 64'd0);
    chk("rstmid_lo", {32'd0, bus.lo_o}, 64'd0);
    chk("rstmid_tag", {57'd0, bus.tag_o}, 64'd0);
    chk("rstmid_flags", {58'd0, bus.flags_o}, 64'd0);
    chk("rstmid_ready", {63'd0, bus.ready_o}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus.valid_o === 1'b1) seen++;
    end
    chk("rstmid_no_valid", 64'(seen), 64'd0);
    next_cycle();

    issue(OP_DIV, 7'h51, 32'd7, 32'hFFFFFFFE);
    finish_op("div_7dm2", 33, 7'h51, 32'd1, 32'hFFFFFFFD, 6'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/iter_muldiv_unit.md
ITER_MULDIV_UNIT -- requirements
Module: iter_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; even, >=8.
REQ-002 SHALL have parameter STEP, default 1, bits retired per iteration cycle; must divide DATA_W.
REQ-003 SHALL have parameter TAG_W, default 7, instruction tag width.
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  squash in-flight op and any same-cycle input
- valid_i  in  1  op presented
- ready_o  out  1  unit can accept
- opcode_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- tag_i  in  TAG_W  instruction tag
- data1_i  in  DATA_W  multiplicand / dividend
- data2_i  in  DATA_W  multiplier / divisor
- valid_o  out  1  result valid, one-cycle pulse
- tag_o  out  TAG_W  tag of completed op
- hi_o  out  DATA_W  HI result
- lo_o  out  DATA_W  LO result
- flags_o  out  6  execution flags

Function
REQ-005 SHALL implement FSM IDLE, CALC, DONE; ready_o=1 only in IDLE with flush_i=0.
REQ-006 SHALL accept an op when valid_i & ready_o; operands, opcode and tag captured that cycle.
REQ-007 SHALL go IDLE->CALC on accept, except DIV/DIVU with data2_i=0, which go IDLE->DONE.
REQ-008 SHALL stay in CALC exactly N=DATA_W/STEP cycles via an iteration counter, then enter DONE.
REQ-009 SHALL assert valid_o only in DONE, for exactly one cycle, then return to IDLE; no output backpressure.
REQ-010 SHALL give latency: accept in cycle T -> valid_o in T+N+1; divide-by-zero -> valid_o in T+1.
REQ-011 SHALL register hi_o, lo_o, tag_o, flags_o, updating them only on DONE entry; they hold otherwise.
REQ-012 MULT/MULTU: {hi_o,lo_o} SHALL equal full 2*DATA_W signed/unsigned product.
REQ-013 DIV/DIVU: lo_o SHALL be quotient truncated toward zero, hi_o remainder with sign of dividend.
REQ-014 Signed ops SHALL operate on magnitudes and sign-correct at DONE; most-negative / -1 yields lo_o=most-negative, hi_o=0, no exception.
REQ-015 Divide by zero SHALL yield hi_o=data1_i, lo_o=all ones, flags_o[1]=1.
REQ-016 flags_o SHALL be {0,1,0,1,exc,0} on completion: bit2 executed, bit1 exception (divide by zero only), bit0 mispredict always 0.
REQ-017 flush_i=1 in any state SHALL force IDLE next cycle, suppress valid_o that cycle and next, and leave registered outputs unchanged.
REQ-018 flush_i coinciding with DONE SHALL suppress that valid_o pulse.
REQ-019 valid_i while ready_o=0 SHALL be ignored; no queuing.

Reset
REQ-020 reset SHALL dominate flush_i and valid_i.
REQ-021 On reset: state IDLE, counter 0, valid_o=0, hi_o=0, lo_o=0, tag_o=0, flags_o=0; ready_o=1 the cycle after reset deasserts.
REQ-022 reset mid-CALC SHALL abort the op with no valid_o.

Verification (DATA_W=32, STEP=1)
REQ-023 MULT -3 x 5, tag 0x12, accepted T -> valid_o at T+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1, tag_o=0x12, flags=0x14.
REQ-024 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-025 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, flags=0x14.
REQ-026 DIVU 9 / 0 accepted T -> valid_o at T+1, hi=9, lo=0xFFFFFFFF, flags=0x16.
REQ-027 flush_i at T+10 of a MULT -> no valid_o, ready_o=1 at T+11, outputs unchanged; new op accepted T+11 completes at T+44.
REQ-028 reset at T+20 of a DIV -> no valid_o, all outputs 0, ready_o=1 after reset release.
